// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage with PC register and IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  PC_sel,
  input  logic        flush,
  input  logic [15:0] imm16_D,
  input  logic [25:0] imm26_D,
  input  logic [31:0] RD1_D,
  input  logic [31:0] instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D
);
  logic [31:0] br_target, j_target, next_pc;
  // Branch/jump targets are relative to the control instruction sitting in D.
  assign br_target = PC_D + 32'd4 + {{14{imm16_D[15]}}, imm16_D, 2'b00};
  assign j_target  = {PC_D[31:28], imm26_D, 2'b00};
  always_comb
    next_pc = PC_sel == 3'b001 ? br_target :
              PC_sel == 3'b010 ? j_target :
              PC_sel == 3'b011 ? RD1_D : PC_F + 32'd4;
  assign PC8_D = PC_D + 32'd8;
  always_ff @(posedge clk) begin
    if (reset) begin
      PC_F    <= RESET_PC;
      instr_D <= NOP;
      PC_D    <= RESET_PC;
    end else if (!stall) begin
      PC_F    <= next_pc;
      instr_D <= flush ? NOP : instr_F;
      PC_D    <= PC_F;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random checks of fetch_stage against a behavioural PC/IF-ID model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [2:0]  PC_sel;
  logic [15:0] imm16_D;
  logic [25:0] imm26_D;
  logic [31:0] RD1_D, instr_F, PC_F, instr_D, PC_D, PC8_D;
  int errors = 0, checks = 0;
  logic [31:0] m_pcf, m_instr, m_pcd;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .PC_sel(PC_sel), .flush(flush),
    .imm16_D(imm16_D), .imm26_D(imm26_D), .RD1_D(RD1_D), .instr_F(instr_F),
    .PC_F(PC_F), .instr_D(instr_D), .PC_D(PC_D), .PC8_D(PC8_D)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  assign instr_F = imem(PC_F);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [2:0] sel, input logic f,
                      input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rd1);
    longint tgt;
    reset = r; stall = s; PC_sel = sel; flush = f;
    imm16_D = i16; imm26_D = i26; RD1_D = rd1;
    case (sel)
      3'd1:    tgt = longint'(m_pcd) + 4 + 4 * longint'($signed(i16));
      3'd2:    tgt = longint'(m_pcd[31:28]) * 64'h1000_0000 + longint'(i26) * 4;
      3'd3:    tgt = longint'(rd1);
      default: tgt = longint'(m_pcf) + 4;
    endcase
    @(posedge clk);
    if (r) begin
      m_pcf = 32'h3000; m_instr = 32'h0; m_pcd = 32'h3000;
    end else if (!s) begin
      m_instr = f ? 32'h0 : imem(m_pcf);
      m_pcd = m_pcf;
      m_pcf = tgt[31:0];
    end
    #1;
    chk("pc_f", PC_F, m_pcf);
    chk("instr_d", instr_D, m_instr);
    chk("pc_d", PC_D, m_pcd);
    chk("pc8_d", PC8_D, m_pcd + 32'd8);
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++)
      step(1, 1'($urandom), 3'($urandom), 1'($urandom), 16'($urandom), 26'($urandom), $urandom);
  endtask

  initial begin
    m_pcf = 0; m_instr = 0; m_pcd = 0;
    do_reset();
    chk("rst_pcf", PC_F, 32'h3000);
    chk("rst_instr", instr_D, 32'h0);
    chk("rst_pc8", PC8_D, 32'h3008);
    seq(2);
    chk("seq_pcf", PC_F, 32'h3008);
    chk("seq_instr", instr_D, imem(32'h3004));
    step(0, 0, 3'd1, 0, 16'h0003, 26'h0, 32'h0);
    chk("br_fwd", PC_F, 32'h3014);
    chk("br_slot", instr_D, imem(32'h3008));
    seq(1);
    chk("br_tgt_d", instr_D, imem(32'h3014));
    do_reset(); seq(2);
    step(0, 0, 3'd1, 0, 16'hFFFF, 26'h0, 32'h0);
    chk("br_back", PC_F, 32'h3004);
    do_reset(); seq(5);
    chk("pc8_3010", PC8_D, 32'h3018);
    step(0, 0, 3'd2, 0, 16'h0, 26'h0000C40, 32'h0);
    chk("j_tgt", PC_F, 32'h3100);
    do_reset(); seq(5);
    step(0, 0, 3'd3, 0, 16'h0, 26'h0, 32'h3200);
    chk("jr_tgt", PC_F, 32'h3200);
    do_reset(); seq(8);
    step(0, 0, 3'd0, 1, 16'h0, 26'h0, 32'h0);
    chk("fl_instr", instr_D, 32'h0);
    chk("fl_pcd", PC_D, 32'h3020);
    chk("fl_pcf", PC_F, 32'h3024);
    for (int i = 0; i < 3; i++) step(0, 1, 3'd1, 1, 16'h0010, 26'h0, 32'h0);
    chk("stall_pcf", PC_F, 32'h3024);
    step(0, 0, 3'd1, 0, 16'h0010, 26'h0, 32'h0);
    chk("stall_br", PC_F, 32'h3064);
    step(0, 0, 3'd3, 0, 16'h0, 26'h0, 32'hFFFF_FFFC);
    step(0, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    chk("wrap", PC_F, 32'h0);
    step(0, 0, 3'd5, 0, 16'h0, 26'h0, 32'h1234);
    chk("illegal_sel", PC_F, 32'h4);
    step(0, 0, 3'd2, 1, 16'h0, 26'h3FF_FFFF, 32'h0);
    chk("fl_j_instr", instr_D, 32'h0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 30) == 0, $urandom_range(0, 3) == 0, 3'($urandom),
           $urandom_range(0, 4) == 0, 16'($urandom), 26'($urandom), $urandom);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS core. Holds the program counter and computes next-PC from the D-stage branch unit's `PC_sel` and `flush` decisions. Drives the instruction-memory address and latches the fetched instruction into the D stage. Branches and jumps have one architectural delay slot.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_3000: PC value after reset.
- `NOP`, default 32'h0000_0000: instruction word inserted into D on flush.

Ports (name, direction, width, meaning):
- `clk` input 1: sole clock, rising-edge.
- `reset` input 1: synchronous, active-high.
- `stall` input 1: from the hazard unit; freezes PC and IF/ID.
- `PC_sel` input 3: from the branch unit. 000 = PC+4, 001 = branch taken, 010 = j/jal, 011 = jr.
- `flush` input 1: from the branch unit; annul the delay-slot instruction now in F.
- `imm16_D` input 16: offset field of the D-stage instruction.
- `imm26_D` input 26: index field of the D-stage instruction.
- `RD1_D` input 32: forwarded rs value in D; the jr target.
- `instr_F` input 32: instruction-memory read data for `PC_F`. Combinational.
- `PC_F` output 32: fetch address to instruction memory.
- `instr_D` output 32: IF/ID instruction register.
- `PC_D` output 32: IF/ID PC register.
- `PC8_D` output 32: `PC_D + 8`, the link address for jal/jalr. Combinational from `PC_D`.

## Operation

- Next-PC is computed combinationally and is selected by `PC_sel`. All address arithmetic is 32-bit modulo 2^32; wrap-around is silent.
  - 000: `PC_F + 4`.
  - 001: `PC_D + 4 + (sign_extend(imm16_D) << 2)`.
  - 010: `{PC_D[31:28], imm26_D, 2'b00}`.
  - 011: `RD1_D`, used unmodified. No alignment check in this block.
  - 100–111: treated as 000.
- Branch and jump targets are always relative to `PC_D`, the PC of the control instruction. The delay-slot instruction in F is fetched normally unless `flush` is asserted.
- Register update on each rising edge, in priority order:
  1. `reset`: `PC_F <= RESET_PC`, `instr_D <= NOP`, `PC_D <= RESET_PC`.
  2. `stall`: `PC_F`, `instr_D` and `PC_D` all hold. `PC_sel` and `flush` are ignored this cycle; the branch unit re-evaluates them next cycle.
  3. `flush`: `PC_F <= next-PC`, `instr_D <= NOP`, `PC_D <= PC_F`.
  4. Otherwise: `PC_F <= next-PC`, `instr_D <= instr_F`, `PC_D <= PC_F`.
- Flush together with a non-zero `PC_sel`: both take effect. D receives NOP and PC takes the selected target. The current branch unit never generates this combination, but the block handles it.
- No internal state other than the three registers. No handshake with memory; instruction memory responds in the same cycle.

## Timing

- Reset values:
  - `PC_F` = 32'h0000_3000.
  - `instr_D` = 0.
  - `PC_D` = 32'h0000_3000.
  - `PC8_D` = 32'h0000_3008.
- Reset asserted mid-program overrides stall, flush and `PC_sel` on that edge. The first fetch after reset deassertion is at `RESET_PC`.
- Fetch latency: an instruction at `PC_F` in cycle n appears on `instr_D` in cycle n+1 if that edge is neither stalled nor flushed.
- Redirect latency: a control instruction in D in cycle n is followed by:
  - its delay slot entering D in cycle n+1;
  - the target on `PC_F` in cycle n+1;
  - the target instruction in D in cycle n+2.
- Stall may last any number of cycles. The redirect is applied on the first unstalled edge, using the `PC_sel` value present at that edge.
- `PC8_D` settles combinationally within the cycle, with no extra register delay.

## Test plan

- **Reset:** hold `reset` 2 cycles with random inputs, then release and feed sequential instructions. Expect `PC_F` = 3000, 3004, 3008 and `instr_D` lagging one cycle.
- **Taken branch:** `PC_D` = 3004, `imm16_D` = 16'h0003, `PC_sel` = 001. Expect next `PC_F` = 3014 and the delay slot at 3008 entering D. With `imm16_D` = 16'hFFFF, expect `PC_F` = 3004.
- **j and jr:** `PC_D` = 3010, `imm26_D` = 26'h0000C40, `PC_sel` = 010 → `PC_F` = 0000_3100. `PC_sel` = 011 with `RD1_D` = 0000_3200 → `PC_F` = 3200. Check `PC8_D` = 3018.
- **Flush:** `flush` = 1, `PC_sel` = 000, `PC_F` = 3020. Expect `instr_D` = 0, `PC_D` = 3020, `PC_F` = 3024.
- **Stall priority:** assert `stall` for 3 cycles with `flush` = 1 and `PC_sel` = 001. Expect all registers frozen. On release with `PC_sel` = 001, expect the branch target to be taken.
- **Wrap and illegal select:** `PC_F` = FFFF_FFFC, `PC_sel` = 000 → 0000_0000. `PC_sel` = 101 → `PC_F + 4`.
